// File: rtl/hazard_ctrl.sv
// Decode-stage hazard/sequencing controller: tracks in-flight destination registers,
// interlocks RAW hazards, sequences redirect flushes. Optional macro: HAZARD_FORWARD_EN.
module hazard_ctrl #(
  parameter int NUM_SLOTS    = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid,
  input  logic [4:0]           dec_rs1_addr,
  input  logic [4:0]           dec_rs2_addr,
  input  logic                 dec_uses_rs1,
  input  logic                 dec_uses_rs2,
  input  logic [4:0]           dec_rd_addr,
  input  logic                 dec_writes_rd,
  input  logic                 dec_is_load,
  input  logic                 pipe_hold,
  input  logic                 ex_redirect,
  output logic                 stall,
  output logic                 insert_nop,
  output logic                 flush,
  output logic                 fetch_stall,
  output logic [CNT_WIDTH-1:0] hazard_cnt
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_RELOAD = FW'(FLUSH_CYCLES - 1);
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic [NUM_SLOTS-1:0]      r_vld;
  logic [NUM_SLOTS-1:0]      r_wr;
  logic [NUM_SLOTS-1:0]      r_ld;
  logic [NUM_SLOTS-1:0][4:0] r_rd;
  logic [FW-1:0]             r_flush_cnt;
  logic [CNT_WIDTH-1:0]      r_hazard_cnt;

  logic [NUM_SLOTS-1:0]      w_slot_hit;
  logic                      w_hazard;
  logic                      w_flush_active;
  logic                      w_bubble;
  logic                      w_issue;

  // With forwarding only a load sitting in slot0 can still be unresolved at use.
  always_comb begin
    w_slot_hit = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_slot_hit[i] = r_vld[i] && r_wr[i] && (r_rd[i] != 5'd0) &&
                      ((dec_uses_rs1 && (r_rd[i] == dec_rs1_addr)) ||
                       (dec_uses_rs2 && (r_rd[i] == dec_rs2_addr))) &&
                      (!FWD_EN || ((i == 0) && r_ld[i]));
    end
  end

  assign w_hazard       = dec_valid && (|w_slot_hit);
  assign w_flush_active = ex_redirect || (r_flush_cnt != '0);
  assign w_bubble       = !w_flush_active && !pipe_hold && w_hazard;
  assign w_issue        = !w_flush_active && !w_hazard;

  always_comb begin
    stall       = 1'b0;
    insert_nop  = 1'b0;
    flush       = 1'b0;
    fetch_stall = 1'b0;
    if (reset) begin
      fetch_stall = 1'b1;
    end else if (w_flush_active) begin
      flush = 1'b1;
    end else if (pipe_hold) begin
      stall       = 1'b1;
      fetch_stall = 1'b1;
    end else if (w_hazard) begin
      insert_nop  = 1'b1;
      fetch_stall = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld        <= '0;
      r_flush_cnt  <= '0;
      r_hazard_cnt <= '0;
    end else begin
      if (w_flush_active) begin
        r_flush_cnt <= ex_redirect ? FLUSH_RELOAD : r_flush_cnt - FW'(1);
      end
      // A held pipeline keeps its slots, but a flush still kills the decode output.
      if (!pipe_hold) begin
        for (int i = NUM_SLOTS - 1; i > 0; i--) begin
          r_vld[i] <= r_vld[i-1];
        end
        r_vld[0] <= w_issue && dec_valid;
      end else if (w_flush_active) begin
        r_vld[0] <= 1'b0;
      end
      if (w_bubble && (r_hazard_cnt != '1)) begin
        r_hazard_cnt <= r_hazard_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Slot payload is qualified by r_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!pipe_hold) begin
      for (int i = NUM_SLOTS - 1; i > 0; i--) begin
        r_rd[i] <= r_rd[i-1];
        r_wr[i] <= r_wr[i-1];
        r_ld[i] <= r_ld[i-1];
      end
      r_rd[0] <= dec_rd_addr;
      r_wr[0] <= dec_writes_rd;
      r_ld[0] <= dec_is_load;
    end
  end

  assign hazard_cnt = r_hazard_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a reference model pushes expected controls per cycle,
// directed scenarios add fixed-value checks; a 2-bit-counter instance checks saturation.
module tb_hazard_ctrl;

  localparam int NS = 3;
  localparam int FC = 2;
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, dec_valid, dec_uses_rs1, dec_uses_rs2, dec_writes_rd, dec_is_load;
  logic pipe_hold, ex_redirect;
  logic [4:0] dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
  logic stall, insert_nop, flush, fetch_stall;
  logic [31:0] hazard_cnt;
  logic s_stall, s_nop, s_flush, s_fs;
  logic [1:0] s_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.NUM_SLOTS(NS), .FLUSH_CYCLES(FC), .CNT_WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
    .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
    .dec_rd_addr(dec_rd_addr), .dec_writes_rd(dec_writes_rd), .dec_is_load(dec_is_load),
    .pipe_hold(pipe_hold), .ex_redirect(ex_redirect),
    .stall(stall), .insert_nop(insert_nop), .flush(flush), .fetch_stall(fetch_stall),
    .hazard_cnt(hazard_cnt)
  );

  hazard_ctrl #(.NUM_SLOTS(NS), .FLUSH_CYCLES(FC), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
    .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
    .dec_rd_addr(dec_rd_addr), .dec_writes_rd(dec_writes_rd), .dec_is_load(dec_is_load),
    .pipe_hold(pipe_hold), .ex_redirect(ex_redirect),
    .stall(s_stall), .insert_nop(s_nop), .flush(s_flush), .fetch_stall(s_fs),
    .hazard_cnt(s_cnt)
  );

  typedef struct packed {logic v; logic [4:0] rd; logic w; logic l;} slot_t;
  typedef struct {logic stall; logic nop; logic flush; logic fs; logic [31:0] cnt; logic [1:0] sat;} exp_t;

  slot_t  m_s [NS];
  int     m_fc;
  longint m_cnt;
  exp_t   sb_q [$];
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_haz();
    bit h = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (m_s[i].v && m_s[i].w && m_s[i].rd != 5'd0 &&
          ((dec_uses_rs1 && m_s[i].rd == dec_rs1_addr) ||
           (dec_uses_rs2 && m_s[i].rd == dec_rs2_addr))) begin
        if (!FWD) h = 1'b1;
        else if (i == 0 && m_s[i].l) h = 1'b1;
      end
    end
    return dec_valid && h;
  endfunction

  function automatic exp_t m_expect();
    exp_t e;
    bit fa = ex_redirect || (m_fc != 0);
    e.stall = 0; e.nop = 0; e.flush = 0; e.fs = 0;
    e.cnt = 32'(m_cnt);
    e.sat = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
    if (reset)          e.fs = 1;
    else if (fa)        e.flush = 1;
    else if (pipe_hold) begin e.stall = 1; e.fs = 1; end
    else if (m_haz())   begin e.nop = 1; e.fs = 1; end
    return e;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NS; i++) m_s[i] = '0;
    m_fc = 0;
    m_cnt = 0;
  endtask

  task automatic m_shift(input slot_t in0);
    for (int i = NS - 1; i > 0; i--) m_s[i] = m_s[i-1];
    m_s[0] = in0;
  endtask

  // Evaluated on pre-edge inputs, right after the edge.
  task automatic m_update(input bit rst, input bit fa, input bit hold, input bit h, input slot_t in0);
    if (rst) m_clear();
    else if (fa) begin
      m_fc = ex_redirect ? FC - 1 : m_fc - 1;
      if (!hold) m_shift('0);
      else m_s[0].v = 1'b0;
    end else if (hold) begin
    end else if (h) begin
      m_shift('0);
      if (m_cnt != 64'hFFFF_FFFF) m_cnt++;
    end else begin
      m_shift(dec_valid ? slot_t'{1'b1, dec_rd_addr, dec_writes_rd, dec_is_load} : slot_t'('0));
    end
  endtask

  task automatic step(input string tag);
    exp_t  e;
    bit    fa, h, rst, hold;
    slot_t in0;
    sb_q.push_back(m_expect());
    fa = ex_redirect || (m_fc != 0); h = m_haz(); rst = reset; hold = pipe_hold;
    in0 = slot_t'{dec_valid, dec_rd_addr, dec_writes_rd, dec_is_load};
    #2;
    e = sb_q.pop_front();
    chk_eq({tag, ".stall"}, stall, e.stall);
    chk_eq({tag, ".nop"}, insert_nop, e.nop);
    chk_eq({tag, ".flush"}, flush, e.flush);
    chk_eq({tag, ".fetch_stall"}, fetch_stall, e.fs);
    chk_eq({tag, ".cnt"}, hazard_cnt, e.cnt);
    chk_eq({tag, ".sat_cnt"}, s_cnt, e.sat);
    @(posedge clk);
    m_update(rst, fa, hold, h, in0);
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic wr, input logic ld);
    dec_valid = v; dec_rs1_addr = rs1; dec_uses_rs1 = u1;
    dec_rs2_addr = rs2; dec_uses_rs2 = u2;
    dec_rd_addr = rd; dec_writes_rd = wr; dec_is_load = ld;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) step("idle");
  endtask

  initial begin
    reset = 1; pipe_hold = 0; ex_redirect = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_clear();
    step("reset");
    reset = 0;

    // RAW on an ALU result
    set_in(1, 1, 1, 0, 0, 5, 1, 0); step("addi_x5");
    set_in(1, 5, 1, 1, 1, 6, 1, 0); repeat (4) step("add_x6");
    idle(3);
    chk_eq("alu_raw_cnt", hazard_cnt, FWD ? 0 : 3);

    // load-use
    set_in(1, 2, 1, 0, 0, 5, 1, 1); step("lw_x5");
    set_in(1, 5, 1, 3, 1, 6, 1, 0); repeat (4) step("use_x5");
    idle(3);
    chk_eq("load_use_cnt", hazard_cnt, FWD ? 1 : 6);

    // x0 destination never interlocks
    set_in(1, 1, 1, 0, 0, 0, 1, 0); step("wr_x0");
    set_in(1, 0, 1, 0, 1, 4, 1, 0); #1 chk_eq("x0_no_haz", insert_nop, 0); step("rd_x0");
    // unused rs2 field matching a pending rd
    set_in(1, 1, 1, 0, 0, 7, 1, 0); step("wr_x7");
    set_in(1, 1, 1, 7, 0, 3, 1, 0); #1 chk_eq("rs2_unused", insert_nop, 0); step("rs2_off");
    idle(3);

    // redirect coinciding with a hazard; squashed x9 must not linger
    set_in(1, 1, 1, 0, 0, 8, 1, 0); step("wr_x8");
    set_in(1, 8, 1, 0, 0, 9, 1, 0); ex_redirect = 1;
    #1 chk_eq("redir_flush", flush, 1); chk_eq("redir_nop", insert_nop, 0);
    step("redirect");
    ex_redirect = 0;
    #1 chk_eq("flush_2nd", flush, 1);
    step("flush2");
    set_in(1, 9, 1, 0, 0, 0, 0, 0);
    #1 chk_eq("flush_done", flush, 0); chk_eq("squashed_rd", insert_nop, 0);
    step("rd_x9");
    chk_eq("redir_cnt", hazard_cnt, FWD ? 1 : 6);
    idle(3);

    // downstream hold over a pending hazard
    set_in(1, 1, 1, 0, 0, 10, 1, 0); step("wr_x10");
    set_in(1, 10, 1, 0, 0, 11, 1, 0); pipe_hold = 1;
    for (int k = 0; k < 4; k++) begin
      #1 chk_eq("hold_stall", stall, 1); chk_eq("hold_nop", insert_nop, 0);
      step("hold");
    end
    pipe_hold = 0;
    chk_eq("hold_cnt", hazard_cnt, FWD ? 1 : 6);
    repeat (4) step("after_hold");
    chk_eq("post_hold_cnt", hazard_cnt, FWD ? 1 : 9);
    chk_eq("sat_cnt", s_cnt, FWD ? 1 : 3);
    idle(3);

    // reset mid-flush with full slots
    set_in(1, 0, 0, 0, 0, 11, 1, 0); step("wr_x11");
    set_in(1, 0, 0, 0, 0, 12, 1, 0); step("wr_x12");
    set_in(1, 0, 0, 0, 0, 13, 1, 1); step("wr_x13");
    set_in(0, 0, 0, 0, 0, 0, 0, 0); ex_redirect = 1; step("redir2");
    ex_redirect = 0; reset = 1;
    #1 chk_eq("rst_flush", flush, 0); chk_eq("rst_fs", fetch_stall, 1);
    step("mid_reset");
    reset = 0;
    set_in(1, 12, 1, 13, 1, 1, 1, 0);
    #1 chk_eq("post_rst_flush", flush, 0); chk_eq("post_rst_nop", insert_nop, 0);
    chk_eq("post_rst_stall", stall, 0); chk_eq("post_rst_fs", fetch_stall, 0);
    chk_eq("post_rst_cnt", hazard_cnt, 0);
    step("after_reset");

    // constrained random traffic against the model
    for (int k = 0; k < 400; k++) begin
      set_in(($urandom_range(3) != 0), 5'($urandom_range(7)), 1'($urandom),
             5'($urandom_range(7)), 1'($urandom), 5'($urandom_range(7)),
             1'($urandom), 1'($urandom));
      ex_redirect = ($urandom_range(9) == 0);
      pipe_hold   = ($urandom_range(5) == 0);
      reset       = ($urandom_range(79) == 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
